// File: rtl/lenet_layer_sched_pkg.sv
// lenet_layer_sched_pkg: shared scheduler state encoding, layer indices and default channel table.
package lenet_layer_sched_pkg;
    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_SEL   = 3'd1,
        S_ISSUE = 3'd2,
        S_WAIT  = 3'd3,
        S_DONE  = 3'd4,
        S_ERR   = 3'd5
    } state_t;

    localparam int L_CONV1 = 0;
    localparam int L_POOL1 = 1;
    localparam int L_CONV2 = 2;
    localparam int L_POOL2 = 3;
    localparam int L_FC    = 4;

    // Field i (LSB first) is the number of output-channel passes of layer i.
    localparam logic [24:0] LAYER_CH_DEF = {5'd1, 5'd16, 5'd16, 5'd6, 5'd6};
endpackage

// File: rtl/lenet_sched_wdt.sv
// lenet_sched_wdt: wait-state watchdog; expire is a registered copy of cnt >= TIMEOUT-1.
module lenet_sched_wdt #(
    parameter int TO_W    = 16,
    parameter int TIMEOUT = 50000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic expire
);
    logic [TO_W-1:0] cnt, cnt_nxt;

    assign cnt_nxt = clr ? '0 : en ? cnt + 1'b1 : cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt    <= '0;
            expire <= 1'b0;
        end else begin
            cnt    <= cnt_nxt;
            expire <= !clr && en && (cnt_nxt >= TO_W'(TIMEOUT - 1));
        end
    end
endmodule

// File: rtl/lenet_layer_sched.sv
// lenet_layer_sched: sequences conv1..fc one output channel at a time, with a stuck-layer watchdog.
module lenet_layer_sched
    import lenet_layer_sched_pkg::*;
#(
    parameter int                      N_LAYER  = 5,
    parameter int                      LI_W     = 3,
    parameter int                      CH_W     = 5,
    parameter logic [N_LAYER*CH_W-1:0] LAYER_CH = LAYER_CH_DEF,
    parameter int                      TO_W     = 16,
    parameter int                      TIMEOUT  = 50000
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               net_start,
    input  logic               abort,
    input  logic [N_LAYER-1:0] layer_done,
    output logic [N_LAYER-1:0] layer_start,
    output logic [LI_W-1:0]    layer_idx,
    output logic [CH_W-1:0]    chan_idx,
    output logic               busy,
    output logic               net_done,
    output logic               err
);
    state_t             state;
    logic [CH_W-1:0]    ch_tab [N_LAYER];
    logic [CH_W-1:0]    n_ch;
    logic [N_LAYER-1:0] one_hot;
    logic               last_layer, last_ch, done_hit, wdt_en, wdt_clr, expire;

    for (genvar i = 0; i < N_LAYER; i++) begin : g_ch
        assign ch_tab[i] = LAYER_CH[i*CH_W +: CH_W];
    end

    assign n_ch       = ch_tab[layer_idx];
    assign one_hot    = N_LAYER'(1) << layer_idx;
    assign last_layer = layer_idx == LI_W'(N_LAYER - 1);
    assign last_ch    = chan_idx == n_ch - 1'b1;
    assign done_hit   = state == S_WAIT && layer_done[layer_idx];
    // Counter reads 0 in the ISSUE cycle and counts ISSUE plus every WAIT cycle after it.
    assign wdt_en     = state == S_ISSUE || state == S_WAIT;
    assign wdt_clr    = !wdt_en || done_hit;

    lenet_sched_wdt #(.TO_W(TO_W), .TIMEOUT(TIMEOUT)) u_wdt (
        .clk    (clk),
        .rst_n  (rst_n),
        .clr    (wdt_clr),
        .en     (wdt_en),
        .expire (expire)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_IDLE;
            layer_idx   <= '0;
            chan_idx    <= '0;
            layer_start <= '0;
            busy        <= 1'b0;
            net_done    <= 1'b0;
            err         <= 1'b0;
        end else begin
            layer_start <= '0;
            net_done    <= 1'b0;
            if (abort) begin
                state     <= S_IDLE;
                layer_idx <= '0;
                chan_idx  <= '0;
                busy      <= 1'b0;
                err       <= 1'b0;
            end else begin
                case (state)
                    S_IDLE: if (net_start) begin
                        state     <= S_SEL;
                        busy      <= 1'b1;
                        layer_idx <= '0;
                        chan_idx  <= '0;
                    end
                    S_SEL: if (n_ch == '0) begin
                        if (last_layer) begin
                            state    <= S_DONE;
                            net_done <= 1'b1;
                        end else begin
                            layer_idx <= layer_idx + 1'b1;
                        end
                    end else begin
                        state       <= S_ISSUE;
                        layer_start <= one_hot;
                    end
                    S_ISSUE: state <= S_WAIT;
                    S_WAIT: if (done_hit) begin
                        if (!last_ch) begin
                            chan_idx    <= chan_idx + 1'b1;
                            state       <= S_ISSUE;
                            layer_start <= one_hot;
                        end else begin
                            chan_idx <= '0;
                            if (last_layer) begin
                                state    <= S_DONE;
                                net_done <= 1'b1;
                            end else begin
                                layer_idx <= layer_idx + 1'b1;
                                state     <= S_SEL;
                            end
                        end
                    end else if (expire) begin
                        state <= S_ERR;
                        err   <= 1'b1;
                    end
                    S_DONE: begin
                        state     <= S_IDLE;
                        busy      <= 1'b0;
                        layer_idx <= '0;
                        chan_idx  <= '0;
                    end
                    default: state <= S_ERR;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_lenet_layer_sched.sv
// tb_lenet_layer_sched: randomized done latencies and noise against a start-schedule model.
module tb_lenet_layer_sched;
    localparam int NL = 5, CW = 5, NI = 3, TO_A = 100;
    localparam logic [NL*CW-1:0] CH_A = {5'd1, 5'd16, 5'd16, 5'd6, 5'd6};
    localparam logic [NL*CW-1:0] CH_B = {5'd1, 5'd16, 5'd16, 5'd0, 5'd6};
    localparam logic [NL*CW-1:0] CH_C = '0;

    logic          clk = 1'b0, rst_n = 1'b1;
    logic          net_start [NI];
    logic          abort     [NI];
    logic [NL-1:0] layer_done  [NI];
    logic [NL-1:0] layer_start [NI];
    logic [2:0]    layer_idx [NI];
    logic [CW-1:0] chan_idx  [NI];
    logic          busy [NI], net_done [NI], err [NI];
    int            cyc = 0, n_chk = 0, n_err = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    lenet_layer_sched #(.LAYER_CH(CH_A), .TIMEOUT(TO_A)) u_a (
        .clk(clk), .rst_n(rst_n), .net_start(net_start[0]), .abort(abort[0]),
        .layer_done(layer_done[0]), .layer_start(layer_start[0]), .layer_idx(layer_idx[0]),
        .chan_idx(chan_idx[0]), .busy(busy[0]), .net_done(net_done[0]), .err(err[0]));
    lenet_layer_sched #(.LAYER_CH(CH_B)) u_b (
        .clk(clk), .rst_n(rst_n), .net_start(net_start[1]), .abort(abort[1]),
        .layer_done(layer_done[1]), .layer_start(layer_start[1]), .layer_idx(layer_idx[1]),
        .chan_idx(chan_idx[1]), .busy(busy[1]), .net_done(net_done[1]), .err(err[1]));
    lenet_layer_sched #(.LAYER_CH(CH_C)) u_c (
        .clk(clk), .rst_n(rst_n), .net_start(net_start[2]), .abort(abort[2]),
        .layer_done(layer_done[2]), .layer_start(layer_start[2]), .layer_idx(layer_idx[2]),
        .chan_idx(chan_idx[2]), .busy(busy[2]), .net_done(net_done[2]), .err(err[2]));

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at cycle %0d", tag, got, exp, cyc);
        end
    endtask

    function automatic int ch_of(input int k, input int l);
        logic [NL*CW-1:0] v;
        v = k == 0 ? CH_A : k == 1 ? CH_B : CH_C;
        return int'(v[l*CW +: CW]);
    endfunction

    task automatic check_idle(input int k, input string tag);
        check({tag, "_busy"}, busy[k], 0);
        check({tag, "_err"}, err[k], 0);
        check({tag, "_net_done"}, net_done[k], 0);
        check({tag, "_start"}, layer_start[k], 0);
        check({tag, "_layer_idx"}, layer_idx[k], 0);
        check({tag, "_chan_idx"}, chan_idx[k], 0);
    endtask

    // One network run: the model lists every (layer, channel) pass and times each start from
    // the previous done: same layer D+1, else one SEL cycle per layer advanced plus ISSUE.
    task automatic run_net(input int k, input int lo, input int hi, input int stall,
                           input int slow, input bit hold);
        int ql[$], qc[$];
        int cnt[NL];
        int now, t_start, t_done, t_end, t_err, t_iss, n, cur, nl;
        bit fin;
        logic [NL-1:0] noise, exp_ls;
        for (int l = 0; l < NL; l++) begin
            cnt[l] = 0;
            for (int c = 0; c < ch_of(k, l); c++) begin
                ql.push_back(l);
                qc.push_back(c);
            end
        end
        @(negedge clk);
        net_start[k] = 1'b1;
        now = cyc;
        n = 0; cur = -1; t_done = -1; t_err = -1; t_iss = -1; fin = 0;
        t_start = ql.size() > 0 ? now + 2 + ql[0] : -1;
        t_end   = ql.size() > 0 ? -1 : now + 1 + NL;
        for (int i = 0; i < 4000 && !fin; i++) begin
            @(negedge clk);
            now = cyc;
            if (!hold) net_start[k] = 1'b0;
            exp_ls = now == t_start ? NL'(1) << ql[n] : '0;
            check("layer_start", layer_start[k], exp_ls);
            check("net_done", net_done[k], now == t_end);
            check("busy", busy[k], 1);
            check("err", err[k], t_err >= 0 && now >= t_err);
            for (int l = 0; l < NL; l++) cnt[l] += int'(layer_start[k][l]);
            if (now == t_start) begin
                check("layer_idx", layer_idx[k], ql[n]);
                check("chan_idx", chan_idx[k], qc[n]);
                cur = ql[n];
                t_iss = now;
                t_start = -1;
                if (n == stall) t_err = now + TO_A;
                else t_done = now + (n == slow ? TO_A - 1 : int'($urandom_range(lo, hi)));
            end
            if (now == t_err) begin
                check("frozen_layer_idx", layer_idx[k], cur);
                check("frozen_chan_idx", chan_idx[k], qc[n]);
                fin = 1;
            end
            noise = $urandom_range(0, 3) == 0 ? NL'($urandom) : '0;
            if (cur >= 0 && now != t_iss) noise[cur] = 1'b0;
            if (now == t_done) begin
                noise[cur] = 1'b1;
                n++;
                t_done = -1;
                if (n < ql.size()) begin
                    nl = ql[n];
                    t_start = now + 1 + (nl - cur);
                end else begin
                    t_end = now + 1 + (NL - 1 - cur);
                end
                cur = -1;
            end
            layer_done[k] = fin ? '0 : noise;
            if (now == t_end) fin = 1;
        end
        check("run_completed", fin, 1);
        layer_done[k] = '0;
        if (stall < 0) begin
            for (int l = 0; l < NL; l++) check("start_count", cnt[l], ch_of(k, l));
            if (!hold) begin
                @(negedge clk);
                check("busy_after", busy[k], 0);
                check("net_done_after", net_done[k], 0);
            end
        end
    endtask

    initial begin
        for (int k = 0; k < NI; k++) begin
            net_start[k] = 1'b0;
            abort[k] = 1'b0;
            layer_done[k] = '0;
        end
        #2 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        for (int k = 0; k < NI; k++) check_idle(k, "reset");
        rst_n = 1'b1;

        run_net(0, 10, 10, -1, -1, 0);
        run_net(0, 2, 15, -1, $urandom_range(0, 44), 0);
        run_net(0, 2, 15, -1, $urandom_range(0, 44), 0);
        run_net(1, 2, 12, -1, -1, 0);
        run_net(2, 2, 2, -1, -1, 0);

        // pool2 first pass never completes: watchdog trips, then abort recovers
        run_net(0, 2, 8, 28, -1, 0);
        repeat (4) begin
            @(negedge clk);
            check("err_sticky", err[0], 1);
            check("err_busy", busy[0], 1);
            check("err_layer_idx", layer_idx[0], 3);
        end
        abort[0] = 1'b1;
        @(negedge clk);
        abort[0] = 1'b0;
        check_idle(0, "abort_err");
        run_net(0, 2, 8, -1, -1, 0);

        @(negedge clk);
        net_start[1] = 1'b1;
        @(negedge clk);
        net_start[1] = 1'b0;
        repeat ($urandom_range(2, 6)) @(negedge clk);
        abort[1] = 1'b1;
        @(negedge clk);
        abort[1] = 1'b0;
        check_idle(1, "abort_run");
        @(negedge clk);
        check("abort_stays_idle", busy[1], 0);

        // net_start held: the finished run restarts from IDLE, then async reset mid-WAIT
        run_net(0, 2, 6, -1, -1, 1);
        @(negedge clk);
        check("hold_idle", busy[0], 0);
        @(negedge clk);
        check("hold_restart", busy[0], 1);
        @(negedge clk);
        check("hold_start", layer_start[0], 1);
        net_start[0] = 1'b0;
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1 check_idle(0, "async_rst");
        @(negedge clk);
        rst_n = 1'b1;
        run_net(0, 2, 10, -1, -1, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule
